// File: rtl/qspi_pkg.sv
// rtl/qspi_pkg.sv - shared opcodes and state encoding for the QSPI PSRAM responder
package qspi_pkg;

    localparam logic [7:0] CMD_READ   = 8'h03;
    localparam logic [7:0] CMD_WRITE  = 8'h02;
    localparam logic [7:0] CMD_QREAD  = 8'hEB;
    localparam logic [7:0] CMD_QWRITE = 8'h38;

    typedef enum logic [3:0] {
        IDLE,
        CMD,
        ADDR_S,
        ADDR_Q,
        DUMMY,
        RDATA_S,
        RDATA_Q,
        WDATA_S,
        WDATA_Q,
        IGNORE
    } state_t;

endpackage

// File: rtl/qspi_psram_responder_spi_in_sync.sv
// rtl/qspi_psram_responder_spi_in_sync.sv - SPI pin synchroniser and SCLK edge detector
module spi_in_sync (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce_n,
    input  logic       sclk,
    input  logic [3:0] sio_i,
    output logic       ce_active,
    output logic       sclk_rise,
    output logic       sclk_fall,
    output logic [3:0] sio
);

    logic [1:0] ce_ff;
    logic [2:0] sclk_ff;
    logic [3:0] sio_ff1;
    logic [3:0] sio_ff2;

    // Two-flop synchronisers; sclk gets a third stage so edges can be seen.
    // sio and sclk have equal depth, so data is aligned with the detected edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ce_ff   <= 2'b11;
            sclk_ff <= 3'b000;
            sio_ff1 <= 4'h0;
            sio_ff2 <= 4'h0;
        end else begin
            ce_ff   <= {ce_ff[0], ce_n};
            sclk_ff <= {sclk_ff[1:0], sclk};
            sio_ff1 <= sio_i;
            sio_ff2 <= sio_ff1;
        end
    end

    assign ce_active = ~ce_ff[1];
    assign sclk_rise = sclk_ff[1] & ~sclk_ff[2];
    assign sclk_fall = ~sclk_ff[1] & sclk_ff[2];
    assign sio       = sio_ff2;

endmodule

// File: rtl/qspi_psram_responder.sv
// rtl/qspi_psram_responder.sv - oversampled SPI/QSPI PSRAM target serving a byte-wide memory port
module qspi_psram_responder
    import qspi_pkg::*;
#(
    parameter int ADDR_W    = 24,
    parameter int DUMMY_CYC = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ce_n,
    input  logic              sclk,
    input  logic [3:0]        sio_i,
    output logic [3:0]        sio_o,
    output logic [3:0]        sio_oe,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    input  logic [7:0]        mem_rdata,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    output logic              busy
);

    logic       ce_active, sclk_rise, sclk_fall;
    logic [3:0] sio_s;

    state_t            state, state_n;
    logic [7:0]        cnt, cnt_n;
    logic [7:0]        sh, sh_n;
    logic [23:0]       addr_sh, addr_sh_n;
    logic              is_write, is_write_n;
    logic              ce_q, rd_load, we_pend, we_pend_n;
    logic [3:0]        sio_o_n, sio_oe_n;
    logic [ADDR_W-1:0] mem_addr_n;
    logic              mem_re_n, mem_we_n;
    logic [7:0]        mem_wdata_n;

    spi_in_sync u_sync (
        .clk       (clk),
        .reset     (reset),
        .ce_n      (ce_n),
        .sclk      (sclk),
        .sio_i     (sio_i),
        .ce_active (ce_active),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .sio       (sio_s)
    );

    assign busy = ce_active;

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            sh        <= 8'h00;
            addr_sh   <= 24'h0;
            is_write  <= 1'b0;
            ce_q      <= 1'b0;
            rd_load   <= 1'b0;
            we_pend   <= 1'b0;
            sio_o     <= 4'h0;
            sio_oe    <= 4'h0;
            mem_addr  <= '0;
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
            mem_wdata <= 8'h00;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            sh        <= sh_n;
            addr_sh   <= addr_sh_n;
            is_write  <= is_write_n;
            ce_q      <= ce_active;
            rd_load   <= mem_re;
            we_pend   <= we_pend_n;
            sio_o     <= sio_o_n;
            sio_oe    <= sio_oe_n;
            mem_addr  <= mem_addr_n;
            mem_re    <= mem_re_n;
            mem_we    <= mem_we_n;
            mem_wdata <= mem_wdata_n;
        end
    end

    // Next-state logic; a ce_n rise outranks any SCLK edge seen on the same clk.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        sh_n        = sh;
        addr_sh_n   = addr_sh;
        is_write_n  = is_write;
        we_pend_n   = 1'b0;
        sio_o_n     = sio_o;
        sio_oe_n    = sio_oe;
        mem_addr_n  = mem_addr;
        mem_re_n    = 1'b0;
        mem_we_n    = we_pend;
        mem_wdata_n = mem_wdata;

        // Write strobe follows the data by one clk, then the address advances.
        if (mem_we)
            mem_addr_n = mem_addr + 1'b1;
        // Read data arrives one clk after mem_re; it is well ahead of the next drive edge.
        if (rd_load && (state == RDATA_S || state == RDATA_Q))
            sh_n = mem_rdata;

        if (state != IDLE && !ce_active) begin
            state_n  = IDLE;
            cnt_n    = 8'd0;
            sio_oe_n = 4'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (ce_active && !ce_q) begin
                        state_n = CMD;
                        cnt_n   = 8'd0;
                    end
                end
                CMD: begin
                    if (sclk_rise) begin
                        sh_n  = {sh[6:0], sio_s[0]};
                        cnt_n = cnt + 1'b1;
                        if (cnt == 8'd7) begin
                            cnt_n = 8'd0;
                            case (sh_n)
                                CMD_READ:   begin state_n = ADDR_S; is_write_n = 1'b0; end
                                CMD_WRITE:  begin state_n = ADDR_S; is_write_n = 1'b1; end
                                CMD_QREAD:  begin state_n = ADDR_Q; is_write_n = 1'b0; end
                                CMD_QWRITE: begin state_n = ADDR_Q; is_write_n = 1'b1; end
                                default:    state_n = IGNORE;
                            endcase
                        end
                    end
                end
                ADDR_S: begin
                    if (sclk_rise) begin
                        addr_sh_n = {addr_sh[22:0], sio_s[0]};
                        cnt_n     = cnt + 1'b1;
                        if (cnt == 8'd23) begin
                            cnt_n      = 8'd0;
                            mem_addr_n = ADDR_W'(addr_sh_n);
                            if (is_write) begin
                                state_n = WDATA_S;
                            end else begin
                                state_n  = RDATA_S;
                                sio_oe_n = 4'b0010;
                                mem_re_n = 1'b1;
                            end
                        end
                    end
                end
                ADDR_Q: begin
                    if (sclk_rise) begin
                        addr_sh_n = {addr_sh[19:0], sio_s};
                        cnt_n     = cnt + 1'b1;
                        if (cnt == 8'd5) begin
                            cnt_n      = 8'd0;
                            mem_addr_n = ADDR_W'(addr_sh_n);
                            if (is_write) begin
                                state_n = WDATA_Q;
                            end else if (DUMMY_CYC == 0) begin
                                state_n  = RDATA_Q;
                                sio_oe_n = 4'b1111;
                                mem_re_n = 1'b1;
                            end else begin
                                state_n = DUMMY;
                            end
                        end
                    end
                end
                DUMMY: begin
                    if (sclk_rise) begin
                        cnt_n = cnt + 1'b1;
                        if (cnt == 8'(DUMMY_CYC - 1)) begin
                            cnt_n    = 8'd0;
                            state_n  = RDATA_Q;
                            sio_oe_n = 4'b1111;
                            mem_re_n = 1'b1;
                        end
                    end
                end
                RDATA_S: begin
                    if (sclk_fall) begin
                        sio_o_n = {2'b00, sh[7], 1'b0};
                        sh_n    = {sh[6:0], 1'b0};
                        cnt_n   = cnt + 1'b1;
                        if (cnt == 8'd7) begin
                            cnt_n      = 8'd0;
                            mem_addr_n = mem_addr + 1'b1;
                            mem_re_n   = 1'b1;
                        end
                    end
                end
                RDATA_Q: begin
                    if (sclk_fall) begin
                        sio_o_n = sh[7:4];
                        sh_n    = {sh[3:0], 4'h0};
                        cnt_n   = cnt + 1'b1;
                        if (cnt == 8'd1) begin
                            cnt_n      = 8'd0;
                            mem_addr_n = mem_addr + 1'b1;
                            mem_re_n   = 1'b1;
                        end
                    end
                end
                WDATA_S: begin
                    if (sclk_rise) begin
                        sh_n  = {sh[6:0], sio_s[0]};
                        cnt_n = cnt + 1'b1;
                        if (cnt == 8'd7) begin
                            cnt_n       = 8'd0;
                            mem_wdata_n = sh_n;
                            we_pend_n   = 1'b1;
                        end
                    end
                end
                WDATA_Q: begin
                    if (sclk_rise) begin
                        sh_n  = {sh[3:0], sio_s};
                        cnt_n = cnt + 1'b1;
                        if (cnt == 8'd1) begin
                            cnt_n       = 8'd0;
                            mem_wdata_n = sh_n;
                            we_pend_n   = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/qspi_psram_responder.md
Name: qspi_psram_responder

Overview:
- Target-side model of the SPI/QSPI PSRAM that the SoC memory controller drives.
- Decodes chip-select, SCLK and SIO[3:0] coming from the SoC's initiator pins and serves reads and writes out of a byte-wide backing memory port.
- Used in the FPGA/system bench in place of a physical PSRAM.
- Oversamples the SPI bus with the local clock. It is not clocked by SCLK.

Parameters:
- ADDR_W, 24, width of the byte address; the address wraps modulo 2^ADDR_W.
- DUMMY_CYC, 6, number of SCLK dummy cycles after the address for command 0xEB.

Ports:
- clk  in  1  system clock; frequency must be at least 8x the SCLK frequency.
- reset  in  1  asynchronous, active-high reset.
- ce_n  in  1  chip select from the initiator, active low.
- sclk  in  1  SPI clock, mode 0.
- sio_i  in  4  SIO[3:0] input; sio_i[0] = SI/MOSI.
- sio_o  out  4  SIO[3:0] output; sio_o[1] = SO/MISO in SPI mode.
- sio_oe  out  4  per-lane output enable, active high.
- mem_addr  out  ADDR_W  backing memory byte address.
- mem_re  out  1  read strobe; mem_rdata is valid on the next clk.
- mem_rdata  in  8  read data.
- mem_we  out  1  write strobe, one clk wide.
- mem_wdata  out  8  write data; qualified by mem_we.
- busy  out  1  high while ce_n is synchronised low.

Behaviour:
- Input synchronisation:
  - ce_n, sclk and sio_i each pass through 2-flop synchronisers.
  - A registered copy of synchronised sclk is used for edge detection.
  - Rising edge: sample. Falling edge: drive.
- Reset values:
  - sio_o = 0, sio_oe = 0.
  - mem_re = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - busy = 0, state = IDLE.
- IDLE: on synchronised ce_n falling → CMD with bit counter = 0.
- CMD: 8 bits on sio_i[0], MSB first, one bit per rising edge. Decode on the 8th bit:
  - 0x03 → ADDR_S, then RDATA_S.
  - 0x02 → ADDR_S, then WDATA_S.
  - 0xEB → ADDR_Q, then DUMMY, then RDATA_Q.
  - 0x38 → ADDR_Q, then WDATA_Q.
  - anything else → IGNORE.
- ADDR_S: 24 rising edges, 1 bit each. ADDR_Q: 6 rising edges, 4 bits each, sio_i[3] = MSB of the nibble.
  - If ADDR_W < 24, the upper address bits are discarded.
- Reads:
  - mem_re pulses for one clk on the clk after the last address bit (or the last dummy bit) is sampled.
  - The returned byte loads the shift register before the next SCLK falling edge. The 8x ratio guarantees this.
  - RDATA_S: sio_oe = 4'b0010. Bit 7 goes out on the first falling edge, then one bit per falling edge.
  - RDATA_Q: sio_oe = 4'b1111. High nibble first.
  - After the last bit or nibble of a byte is driven, mem_addr increments and mem_re pulses to prefetch the next byte. Reads continue indefinitely.
- DUMMY: counts DUMMY_CYC rising edges; sio_oe stays 0.
- Writes:
  - WDATA_S collects 8 rising-edge bits; WDATA_Q collects 2 nibbles.
  - When a byte completes, mem_wdata is set and mem_we pulses one clk later; mem_addr then increments.
- Address wrap: the address increments from 2^ADDR_W−1 to 0.
- IGNORE: sio_oe = 0; all SCLK activity is ignored until ce_n goes high.
- ce_n rising, any state:
  - Next clk: → IDLE, sio_oe = 0, counters cleared.
  - A partially assembled write byte is discarded and mem_we is not pulsed.
  - A pending prefetch is harmless.
- A reset asserted mid-transaction forces all reset values asynchronously.
- A new transaction requires a fresh ce_n falling edge.
- A sclk edge and a ce_n rise on the same synchronised clk: ce_n wins and the edge is dropped.

Decomposition:
- Shared package `qspi_pkg` holds:
  - the command opcode constants CMD_READ = 8'h03, CMD_WRITE = 8'h02, CMD_QREAD = 8'hEB, CMD_QWRITE = 8'h38;
  - the state enum {IDLE, CMD, ADDR_S, ADDR_Q, DUMMY, RDATA_S, RDATA_Q, WDATA_S, WDATA_Q, IGNORE}.
- One sub-module, `spi_in_sync`: the synchroniser plus edge detector. It outputs ce_active, sclk_rise, sclk_fall and the synchronised sio.

Test Plan:
- SPI write then read:
  - Send 0x02, addr 0x000010, data 0xA5, 0x3C.
  - Expect mem_we at addresses 0x10 and 0x11 with data 0xA5 and 0x3C.
  - Then send 0x03, addr 0x000010; expect MISO to return 0xA5, 0x3C, sio_oe = 0010.
- Quad write and quad read:
  - Send 0x38, addr 0x000100, data 0xDE, 0xAD.
  - Send 0xEB, addr 0x000100, with 6 dummy cycles.
  - Expect 0xDE, 0xAD on SIO, nibble-wise, with sio_oe = 1111 only after the dummy cycles.
- Wrap-around: read burst starting at 0xFFFFFF for 2 bytes → mem_addr sequence 0xFFFFFF, 0x000000.
- Unknown opcode: send 0x9F followed by 32 clocks → no mem_re or mem_we, sio_oe stays 0 throughout; the next 0x03 transaction works.
- Abort:
  - Raise ce_n after 5 bits of a write data byte → no mem_we, state returns to IDLE.
  - Raise ce_n mid-read → sio_oe = 0 within 3 clk.
- Reset mid-read: assert reset during RDATA_Q → sio_oe = 0 and busy = 0 immediately; after release, a fresh 0x03 read succeeds.
